// File: rtl/braille_result_uart_tx_pkg.sv
// rtl/braille_result_uart_tx_pkg.sv - shared constants, FSM state type and class-to-ASCII mapping
package braille_result_uart_tx_pkg;

   localparam int          CORE_CO_NUM_CLASS = 26;
   localparam int          UART_CLKS_PER_BIT = 868;
   localparam int          RESULT_FIFO_DEPTH = 8;
   localparam logic [7:0]  ASCII_BASE        = 8'h61;
   localparam logic [7:0]  ASCII_INVALID     = 8'h3F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_e;

   // Out-of-range class indices become '?' so the braille side shows an obvious error glyph.
   function automatic logic [7:0] map_index(input logic [7:0] idx, input int unsigned num_class);
      if (32'(idx) < num_class) begin
         return ASCII_BASE + idx;
      end
      return ASCII_INVALID;
   endfunction

endpackage

// File: rtl/braille_result_uart_tx_result_fifo.sv
// rtl/braille_result_uart_tx_result_fifo.sv - single-clock 8-bit result FIFO with full flag and occupancy count
module result_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          full,
   output logic [AW:0]   count
);

   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_ok;
   logic          rd_ok;

   // Both gates use the registered count, so a write while full drops even if a pop happens the same cycle.
   assign wr_ok   = wr_en & (count_q != CNT_DEPTH);
   assign rd_ok   = rd_en & (count_q != '0);
   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (count_q == CNT_DEPTH);
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/braille_result_uart_tx.sv
// rtl/braille_result_uart_tx.sv - maps classifier argmax to ASCII, queues it and sends 8N1 UART frames
module braille_result_uart_tx
   import braille_result_uart_tx_pkg::*;
#(
   parameter int NUM_CLASS    = CORE_CO_NUM_CLASS,
   parameter int IDX_BW       = $clog2(NUM_CLASS),
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = RESULT_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_valid,
   input  logic [IDX_BW-1:0] i_index_info,
   input  logic              i_clear_ovf,
   output logic              o_tx,
   output logic              o_busy,
   output logic              o_fifo_full,
   output logic              o_overflow,
   output logic [7:0]        o_drop_cnt
);

   localparam int                AW        = $clog2(FIFO_DEPTH);
   localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

   uart_state_e       state_q, state_d;
   logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;

   logic              rise;
   logic              drop;
   logic              pop;
   logic [7:0]        wr_byte;
   logic [7:0]        head_byte;
   logic              fifo_full;
   logic [AW:0]       fifo_count;

   assign rise    = i_valid & ~valid_q;
   assign drop    = rise & fifo_full;
   assign wr_byte = map_index(8'(i_index_info), NUM_CLASS);
   assign valid_d = i_valid;

   result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .wr_en   (rise),
      .wr_data (wr_byte),
      .rd_en   (pop),
      .rd_data (head_byte),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   // A drop in the same cycle as a clear still counts, so software never loses that event.
   always_comb begin
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (i_clear_ovf) begin
            drop_cnt_d = 8'd1;
         end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end else if (i_clear_ovf) begin
         ovf_d      = 1'b0;
         drop_cnt_d = 8'd0;
      end
   end

   // tx_d follows the current state, so o_tx trails the FSM by one cycle for every bit equally.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = 1'b1;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fifo_count != '0) begin
               pop        = 1'b1;
               shift_d    = head_byte;
               bit_cnt_d  = 3'd0;
               baud_cnt_d = '0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            tx_d = 1'b0;
            if (baud_cnt_q == BAUD_LAST) begin
               baud_cnt_d = '0;
               state_d    = ST_DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + BAUD_ONE;
            end
         end
         ST_DATA: begin
            tx_d = shift_q[0];
            if (baud_cnt_q == BAUD_LAST) begin
               baud_cnt_d = '0;
               shift_d    = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + BAUD_ONE;
            end
         end
         ST_STOP: begin
            if (baud_cnt_q == BAUD_LAST) begin
               baud_cnt_d = '0;
               state_d    = ST_IDLE;
            end else begin
               baud_cnt_d = baud_cnt_q + BAUD_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign o_tx        = tx_q;
   assign o_busy      = (state_q != ST_IDLE) | (fifo_count != '0);
   assign o_fifo_full = fifo_full;
   assign o_overflow  = ovf_q;
   assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_braille_result_uart_tx.sv
// tb/tb_braille_result_uart_tx.sv - scoreboard bench decoding UART frames from o_tx
module tb_braille_result_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk;
   logic       reset_n;
   logic       i_valid;
   logic [4:0] i_index_info;
   logic       i_clear_ovf;
   logic       o_tx;
   logic       o_busy;
   logic       o_fifo_full;
   logic       o_overflow;
   logic [7:0] o_drop_cnt;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         frame_cnt = 0;
   logic       mon_busy = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] exp_q[$];
   int         starts[$];

   braille_result_uart_tx #(
      .NUM_CLASS    (26),
      .IDX_BW       (5),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_valid      (i_valid),
      .i_index_info (i_index_info),
      .i_clear_ovf  (i_clear_ovf),
      .o_tx         (o_tx),
      .o_busy       (o_busy),
      .o_fifo_full  (o_fifo_full),
      .o_overflow   (o_overflow),
      .o_drop_cnt   (o_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_byte(input int idx);
      if (idx < 26) return 8'(8'h61 + idx);
      return 8'h3F;
   endfunction

   // Frame monitor: every bit must hold for CPB cycles; byte is taken LSB first.
   initial begin
      logic [9:0] bits;
      logic       glitch;
      int         st;
      forever begin
         @(negedge clk);
         if (reset_n && o_tx == 1'b0) begin
            mon_busy = 1'b1;
            st       = cyc;
            bits     = '0;
            glitch   = 1'b0;
            for (int c = 1; c < FRAME; c++) begin
               @(negedge clk);
               if (c % CPB == 0) bits[c / CPB] = o_tx;
               else if (o_tx !== bits[c / CPB]) glitch = 1'b1;
            end
            if (!abort) begin
               frame_cnt++;
               starts.push_back(st);
               check_eq("stop_bit", 32'(bits[9]), 32'd1);
               check_eq("bit_hold", 32'(glitch), 32'd0);
               if (exp_q.size() == 0) check_eq("unexpected_frame", 32'(bits[8:1]), 32'hFFFF_FFFF);
               else check_eq("frame_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
            end
            mon_busy = 1'b0;
         end
      end
   end

   task automatic pulse(input int idx, input bit push);
      i_valid      = 1'b1;
      i_index_info = 5'(idx);
      if (push) exp_q.push_back(ref_byte(idx));
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !mon_busy && !o_busy) done = 1'b1;
      end
      check_eq("idle_timeout", 32'(done), 32'd1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      int s0;
      int f0;
      bit ok;
      reset_n      = 1'b0;
      i_valid      = 1'b0;
      i_index_info = '0;
      i_clear_ovf  = 1'b0;
      idle_cycles(3);
      reset_n = 1'b1;
      idle_cycles(100);
      check_eq("rst_tx", 32'(o_tx), 32'd1);
      check_eq("rst_busy", 32'(o_busy), 32'd0);
      check_eq("rst_full", 32'(o_fifo_full), 32'd0);
      check_eq("rst_ovf", 32'(o_overflow), 32'd0);
      check_eq("rst_drop", 32'(o_drop_cnt), 32'd0);

      // Single pulse, index 2: o_tx low only after the second edge following the sample.
      i_valid      = 1'b1;
      i_index_info = 5'd2;
      exp_q.push_back(ref_byte(2));
      @(negedge clk);
      i_valid = 1'b0;
      check_eq("lat_n", 32'(o_tx), 32'd1);
      check_eq("busy_after_write", 32'(o_busy), 32'd1);
      @(negedge clk);
      check_eq("lat_n1", 32'(o_tx), 32'd1);
      @(negedge clk);
      check_eq("lat_n2", 32'(o_tx), 32'd0);
      wait_idle();
      check_eq("idle_tx", 32'(o_tx), 32'd1);

      // Level held high: exactly one frame.
      f0           = frame_cnt;
      i_valid      = 1'b1;
      i_index_info = 5'd25;
      exp_q.push_back(ref_byte(25));
      idle_cycles(20);
      i_valid = 1'b0;
      wait_idle();
      idle_cycles(60);
      check_eq("hold_one_frame", 32'(frame_cnt - f0), 32'd1);

      pulse(30, 1'b1);
      wait_idle();

      // Burst of six edges: first is popped at once, four fill the queue, sixth drops.
      s0 = starts.size();
      for (int k = 0; k < 6; k++) begin
         pulse(k, k < 5);
         if (k < 5) @(negedge clk);
      end
      check_eq("burst_full", 32'(o_fifo_full), 32'd1);
      check_eq("burst_ovf", 32'(o_overflow), 32'd1);
      check_eq("burst_drop", 32'(o_drop_cnt), 32'd1);
      wait_idle();
      check_eq("burst_frames", 32'(starts.size() - s0), 32'd5);
      if (starts.size() - s0 == 5) begin
         for (int k = s0 + 1; k < s0 + 5; k++)
            check_eq("burst_gap", 32'(starts[k] - starts[k-1]), 32'(FRAME + 1));
      end
      check_eq("ovf_sticky", 32'(o_overflow), 32'd1);
      i_clear_ovf = 1'b1;
      @(negedge clk);
      i_clear_ovf = 1'b0;
      check_eq("clr_ovf", 32'(o_overflow), 32'd0);
      check_eq("clr_drop", 32'(o_drop_cnt), 32'd0);

      // Reset during data bit 0 of 'h' (0x68, bit0 = 0).
      abort = 1'b1;
      pulse(7, 1'b0);
      idle_cycles(7);
      check_eq("pre_rst_tx", 32'(o_tx), 32'd0);
      #1 reset_n = 1'b0;
      #1 check_eq("rst_async_tx", 32'(o_tx), 32'd1);
      check_eq("rst_async_busy", 32'(o_busy), 32'd0);
      idle_cycles(3);
      reset_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (!mon_busy) ok = 1'b1;
      end
      check_eq("abort_timeout", 32'(ok), 32'd1);
      abort = 1'b0;
      f0 = frame_cnt;
      idle_cycles(100);
      check_eq("post_rst_frames", 32'(frame_cnt - f0), 32'd0);
      check_eq("post_rst_busy", 32'(o_busy), 32'd0);
      check_eq("post_rst_tx", 32'(o_tx), 32'd1);
      check_eq("left_expected", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
